// File: rtl/ds_pkg.sv
// Shared definitions for the downsample output packer: the beat record
// carried through the output FIFO and helpers describing its packed layout.
package ds_pkg;

    localparam int DS_DWIDTH = 8;
    localparam int DS_AWIDTH = 11;

    // One output beat at the default widths; packed MSB-first as
    // {data, col, row, eol, eof}. Other widths use the same field order.
    typedef struct packed {
        logic [DS_DWIDTH-1:0] data;
        logic [DS_AWIDTH-1:0] col;
        logic [DS_AWIDTH-1:0] row;
        logic                 eol;
        logic                 eof;
    } ds_beat_t;

    localparam int DS_BEAT_W = $bits(ds_beat_t);

    // Packed width of a beat for arbitrary data/coordinate widths.
    function automatic int ds_beat_width(input int dw, input int aw);
        return dw + 2 * aw + 2;
    endfunction

endpackage

// File: rtl/ds_out_fifo.sv
// Output FIFO of the pixel packer: up to two writes and one read per cycle.
// Count and the "at least two free slots" flag are registered so that no
// combinational path runs from the write side to the read side.
module ds_out_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       wr_cnt,
    input  logic [WIDTH-1:0] wr_data0,
    input  logic [WIDTH-1:0] wr_data1,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    output logic             wr_ready
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] READY_MAX = CW'(DEPTH - 2);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_p1_s;
    logic [CW-1:0]    count_q, count_d;
    logic             ready_q, ready_d;
    logic [1:0]       wr_n_s;
    logic             pop_s;

    // Next-state: storage writes, pointer advance, count and ready flag.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        wr_ptr_p1_s = wr_ptr_q + PW'(1);
        pop_s       = rd_en && (count_q != {CW{1'b0}});
        case (wr_cnt)
            2'd1: begin
                mem_d[wr_ptr_q] = wr_data0;
                wr_ptr_d        = wr_ptr_p1_s;
                wr_n_s          = 2'd1;
            end
            2'd2: begin
                mem_d[wr_ptr_q]    = wr_data0;
                mem_d[wr_ptr_p1_s] = wr_data1;
                wr_ptr_d           = wr_ptr_q + PW'(2);
                wr_n_s             = 2'd2;
            end
            default: begin
                wr_ptr_d = wr_ptr_q;
                wr_n_s   = 2'd0;
            end
        endcase
        if (pop_s) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end
        count_d = count_q + CW'(wr_n_s) - CW'(pop_s);
        ready_d = (count_d <= READY_MAX);
    end

    // State registers; reset empties the FIFO and zeroes the head.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_q <= {PW{1'b0}};
            rd_ptr_q <= {PW{1'b0}};
            count_q  <= {CW{1'b0}};
            ready_q  <= 1'b1;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ready_q  <= ready_d;
        end
    end

    assign rd_data  = mem_q[rd_ptr_q];
    assign rd_valid = (count_q != {CW{1'b0}});
    assign wr_ready = ready_q;

endmodule

// File: rtl/ds_pixel_packer.sv
// Downsample output packer: compacts kept pixels into a downsampled stream,
// tags each with output column/row and end-of-line/frame markers, and tracks
// per-frame output dimensions and line-length consistency.
module ds_pixel_packer
    import ds_pkg::*;
#(
    parameter int DWIDTH = DS_DWIDTH,
    parameter int AWIDTH = DS_AWIDTH,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clken,
    input  logic              valid_in,
    input  logic              keep,
    input  logic [DWIDTH-1:0] pix_in,
    input  logic [AWIDTH-1:0] cnt_col,
    input  logic [AWIDTH-1:0] cnt_row,
    input  logic [AWIDTH-1:0] width,
    input  logic [AWIDTH-1:0] height,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DWIDTH-1:0] out_data,
    output logic [AWIDTH-1:0] out_col,
    output logic [AWIDTH-1:0] out_row,
    output logic              out_eol,
    output logic              out_eof,
    output logic [AWIDTH-1:0] ds_width,
    output logic [AWIDTH-1:0] ds_height,
    output logic              line_err
);

    localparam int BW = ds_beat_width(DWIDTH, AWIDTH);
    localparam logic [AWIDTH-1:0] A_ZERO = {AWIDTH{1'b0}};
    localparam logic [AWIDTH-1:0] A_ONE  = AWIDTH'(1);

    // Beat layout {data, col, row, eol, eof}, matching ds_beat_t.
    function automatic logic [BW-1:0] pack_beat(
        input logic [DWIDTH-1:0] d,
        input logic [AWIDTH-1:0] c,
        input logic [AWIDTH-1:0] r,
        input logic              e,
        input logic              f
    );
        return {d, c, r, e, f};
    endfunction

    logic [DWIDTH-1:0] pend_data_q, pend_data_d;
    logic [AWIDTH-1:0] pend_col_q, pend_col_d;
    logic [AWIDTH-1:0] pend_row_q, pend_row_d;
    logic              pend_valid_q, pend_valid_d;
    logic [AWIDTH-1:0] col_cnt_q, col_cnt_d;
    logic [AWIDTH-1:0] row_cnt_q, row_cnt_d;
    logic [AWIDTH-1:0] ref_w_q, ref_w_d;
    logic [AWIDTH-1:0] ds_width_q, ds_width_d;
    logic [AWIDTH-1:0] ds_height_q, ds_height_d;
    logic              line_err_q, line_err_d;

    logic              accept_s, le_s, fe_s;
    logic              line_has_s;
    logic [AWIDTH-1:0] line_w_s;
    logic [1:0]        wr_cnt_s;
    logic [BW-1:0]     wr_data0_s, wr_data1_s;
    logic [BW-1:0]     head_s;
    logic              fifo_ready_s, fifo_valid_s;

    assign accept_s = clken && valid_in && fifo_ready_s;
    assign le_s     = (cnt_col == (width - A_ONE));
    assign fe_s     = le_s && (cnt_row == (height - A_ONE));

    // Input-side next state: pending pixel, FIFO writes, line/frame accounting.
    always_comb begin
        pend_data_d  = pend_data_q;
        pend_col_d   = pend_col_q;
        pend_row_d   = pend_row_q;
        pend_valid_d = pend_valid_q;
        col_cnt_d    = col_cnt_q;
        row_cnt_d    = row_cnt_q;
        ref_w_d      = ref_w_q;
        ds_width_d   = ds_width_q;
        ds_height_d  = ds_height_q;
        line_err_d   = line_err_q;
        line_has_s   = 1'b0;
        line_w_s     = col_cnt_q;
        wr_cnt_s     = 2'd0;
        wr_data0_s   = {BW{1'b0}};
        wr_data1_s   = {BW{1'b0}};
        if (accept_s) begin
            if (le_s) begin
                // The held pixel (if any) is this line's last unless the LE beat itself is kept.
                line_has_s = keep || pend_valid_q;
                if (keep) begin
                    line_w_s = col_cnt_q + A_ONE;
                    if (pend_valid_q) begin
                        wr_cnt_s   = 2'd2;
                        wr_data0_s = pack_beat(pend_data_q, pend_col_q, pend_row_q, 1'b0, 1'b0);
                        wr_data1_s = pack_beat(pix_in, col_cnt_q, row_cnt_q, 1'b1, fe_s);
                    end else begin
                        wr_cnt_s   = 2'd1;
                        wr_data0_s = pack_beat(pix_in, col_cnt_q, row_cnt_q, 1'b1, fe_s);
                    end
                end else begin
                    line_w_s = col_cnt_q;
                    if (pend_valid_q) begin
                        wr_cnt_s   = 2'd1;
                        wr_data0_s = pack_beat(pend_data_q, pend_col_q, pend_row_q, 1'b1, fe_s);
                    end else begin
                        wr_cnt_s   = 2'd0;
                    end
                end
                // Empty lines do not count as output rows.
                if (line_has_s) begin
                    if (row_cnt_q == A_ZERO) begin
                        ref_w_d = line_w_s;
                    end else if (line_w_s != ref_w_q) begin
                        line_err_d = 1'b1;
                    end else begin
                        line_err_d = line_err_q;
                    end
                    row_cnt_d = row_cnt_q + A_ONE;
                end else begin
                    row_cnt_d = row_cnt_q;
                end
                col_cnt_d    = A_ZERO;
                pend_valid_d = 1'b0;
                if (fe_s) begin
                    ds_width_d  = ref_w_d;
                    ds_height_d = row_cnt_d;
                    row_cnt_d   = A_ZERO;
                    ref_w_d     = A_ZERO;
                end else begin
                    ds_width_d  = ds_width_q;
                    ds_height_d = ds_height_q;
                end
            end else if (keep) begin
                // A newer kept pixel proves the held one is not end-of-line.
                if (pend_valid_q) begin
                    wr_cnt_s   = 2'd1;
                    wr_data0_s = pack_beat(pend_data_q, pend_col_q, pend_row_q, 1'b0, 1'b0);
                end else begin
                    wr_cnt_s   = 2'd0;
                end
                pend_data_d  = pix_in;
                pend_col_d   = col_cnt_q;
                pend_row_d   = row_cnt_q;
                pend_valid_d = 1'b1;
                col_cnt_d    = col_cnt_q + A_ONE;
            end else begin
                pend_valid_d = pend_valid_q;
            end
        end else begin
            wr_cnt_s = 2'd0;
        end
    end

    // Input-side registers; reset clears pending pixel and all counters.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pend_data_q  <= {DWIDTH{1'b0}};
            pend_col_q   <= A_ZERO;
            pend_row_q   <= A_ZERO;
            pend_valid_q <= 1'b0;
            col_cnt_q    <= A_ZERO;
            row_cnt_q    <= A_ZERO;
            ref_w_q      <= A_ZERO;
            ds_width_q   <= A_ZERO;
            ds_height_q  <= A_ZERO;
            line_err_q   <= 1'b0;
        end else begin
            pend_data_q  <= pend_data_d;
            pend_col_q   <= pend_col_d;
            pend_row_q   <= pend_row_d;
            pend_valid_q <= pend_valid_d;
            col_cnt_q    <= col_cnt_d;
            row_cnt_q    <= row_cnt_d;
            ref_w_q      <= ref_w_d;
            ds_width_q   <= ds_width_d;
            ds_height_q  <= ds_height_d;
            line_err_q   <= line_err_d;
        end
    end

    ds_out_fifo #(
        .WIDTH (BW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_cnt   (wr_cnt_s),
        .wr_data0 (wr_data0_s),
        .wr_data1 (wr_data1_s),
        .rd_en    (out_ready),
        .rd_data  (head_s),
        .rd_valid (fifo_valid_s),
        .wr_ready (fifo_ready_s)
    );

    assign in_ready  = fifo_ready_s;
    assign out_valid = fifo_valid_s;
    assign out_data  = head_s[BW-1 -: DWIDTH];
    assign out_col   = head_s[2*AWIDTH+1 -: AWIDTH];
    assign out_row   = head_s[AWIDTH+1 -: AWIDTH];
    assign out_eol   = head_s[1];
    assign out_eof   = head_s[0];
    assign ds_width  = ds_width_q;
    assign ds_height = ds_height_q;
    assign line_err  = line_err_q;

endmodule
